// File: rtl/wb_pkg.sv
// Shared Wishbone master types: FSM states, default widths and the packed core request.
package wb_pkg;

  localparam int unsigned WbAddrW = 32;
  localparam int unsigned WbDataW = 32;
  localparam int unsigned WbSelW  = WbDataW / 8;

  typedef enum logic [1:0] {
    StIdle,
    StActive,
    StResp
  } wb_state_t;

  typedef struct packed {
    logic               we;
    logic [WbAddrW-1:0] addr;
    logic [WbDataW-1:0] wdata;
    logic [WbSelW-1:0]  sel;
  } wb_req_t;

endpackage

// File: rtl/wb_master_port_if.sv
// Core request/response handshake plus Wishbone classic bus signals for one master port.
interface wb_master_port_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_sel;
  logic                  resp_valid;
  logic [DATA_W-1:0]     resp_rdata;
  logic                  resp_err;
  logic                  cyc_o;
  logic                  stb_o;
  logic                  we_o;
  logic [ADDR_W-1:0]     adr_o;
  logic [DATA_W-1:0]     dat_o;
  logic [DATA_W/8-1:0]   sel_o;
  logic [DATA_W-1:0]     dat_i;
  logic                  ack_i;
  logic                  err_i;

  modport master (
    input  req_valid, req_we, req_addr, req_wdata, req_sel, dat_i, ack_i, err_i,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output cyc_o, stb_o, we_o, adr_o, dat_o, sel_o
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata, req_sel, dat_i, ack_i, err_i,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  cyc_o, stb_o, we_o, adr_o, dat_o, sel_o
  );

endinterface

// File: rtl/wb_timeout_ctr.sv
// Counts bus-active cycles; expired flags the last permitted cycle. Tied off when TIMEOUT is 0.
module wb_timeout_ctr #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  if (TIMEOUT == 0) begin : g_off
    assign expired = 1'b0;
  end else begin : g_cnt
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q <= '0;
      end else if (clear) begin
        cnt_q <= '0;
      end else if (enable) begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end

    assign expired = (cnt_q == CntW'(TIMEOUT - 1));
  end

endmodule

// File: rtl/wb_master_port.sv
// Single-beat Wishbone classic master: IDLE accepts a core request, ACTIVE runs the bus cycle,
// RESP returns a one-cycle completion pulse to the core.
module wb_master_port
  import wb_pkg::*;
#(
  parameter int unsigned ADDR_W  = WbAddrW,
  parameter int unsigned DATA_W  = WbDataW,
  parameter int unsigned TIMEOUT = 16
) (
  input logic              clk,
  input logic              reset,
  wb_master_port_if.master bus
);

  wb_state_t           state_q;
  logic                cyc_q;
  logic                we_q;
  logic [ADDR_W-1:0]   adr_q;
  logic [DATA_W-1:0]   dat_q;
  logic [DATA_W/8-1:0] sel_q;
  logic                resp_valid_q;
  logic                resp_err_q;
  logic [DATA_W-1:0]   resp_rdata_q;
  logic                accept;
  logic                expired;

  // Ready is masked by reset so the core never sees a stale IDLE while reset is held.
  assign bus.req_ready = (state_q == StIdle) && !reset;
  assign accept        = bus.req_valid && bus.req_ready;

  wb_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept),
    .enable (state_q == StActive),
    .expired(expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      cyc_q        <= 1'b0;
      we_q         <= 1'b0;
      adr_q        <= '0;
      dat_q        <= '0;
      sel_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            we_q    <= bus.req_we;
            adr_q   <= bus.req_addr;
            dat_q   <= bus.req_wdata;
            sel_q   <= bus.req_sel;
            cyc_q   <= 1'b1;
            state_q <= StActive;
          end
        end
        StActive: begin
          // Priority: err over ack, ack over timeout.
          if (bus.err_i || bus.ack_i || expired) begin
            cyc_q        <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_err_q   <= bus.err_i || !bus.ack_i;
            resp_rdata_q <= (!bus.err_i && bus.ack_i && !we_q) ? bus.dat_i : '0;
            state_q      <= StResp;
          end
        end
        StResp: begin
          state_q <= StIdle;
        end
        default: begin
          cyc_q   <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.cyc_o      = cyc_q;
  assign bus.stb_o      = cyc_q;
  assign bus.we_o       = we_q;
  assign bus.adr_o      = adr_q;
  assign bus.dat_o      = dat_q;
  assign bus.sel_o      = sel_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_wb_master_port.sv
// Self-checking bench: directed scenarios plus randomized transactions against a latency model.
module tb_wb_master_port;
  import wb_pkg::*;

  localparam int unsigned Timeout = 16;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  wb_master_port_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  wb_master_port #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(Timeout)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Runs one transaction from an IDLE negedge. The slave terminates on ACTIVE cycle 'waits'
  // (0-based) with the given ack/err; waits >= Timeout means the slave never responds.
  task automatic run_txn(input string tag, input wb_req_t r, input int waits, input bit t_err,
                         input bit t_ack, input logic [31:0] rd);
    int          cycles;
    bit          bus_ok;
    bit          ready_ok;
    int          exp_cycles;
    bit          exp_err;
    logic [31:0] exp_rdata;
    bus.req_valid = 1'b1;
    bus.req_we    = r.we;
    bus.req_addr  = r.addr;
    bus.req_wdata = r.wdata;
    bus.req_sel   = r.sel;
    check_eq({tag, "_ready"}, 64'(bus.req_ready), 64'(1));
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_wdata = $urandom;
    cycles   = 0;
    bus_ok   = 1'b1;
    ready_ok = 1'b1;
    while (bus.cyc_o === 1'b1 && cycles < 40) begin
      if (bus.stb_o !== 1'b1 || bus.we_o !== r.we || bus.adr_o !== r.addr ||
          bus.sel_o !== r.sel || (r.we && bus.dat_o !== r.wdata) || bus.resp_valid !== 1'b0)
        bus_ok = 1'b0;
      if (bus.req_ready !== 1'b0) ready_ok = 1'b0;
      if (cycles == waits) begin
        bus.ack_i = t_ack;
        bus.err_i = t_err;
        bus.dat_i = rd;
      end else begin
        bus.ack_i = 1'b0;
        bus.err_i = 1'b0;
        bus.dat_i = $urandom;
      end
      @(negedge clk);
      cycles++;
    end
    bus.ack_i = 1'b0;
    bus.err_i = 1'b0;
    // Reference: the bus cycle lasts until termination or the timeout budget, whichever first.
    if (waits < int'(Timeout)) begin
      exp_cycles = waits + 1;
      exp_err    = t_err;
    end else begin
      exp_cycles = int'(Timeout);
      exp_err    = 1'b1;
    end
    exp_rdata = (!exp_err && !r.we) ? rd : 32'h0;
    check_eq({tag, "_cyc_len"}, 64'(cycles), 64'(exp_cycles));
    check_eq({tag, "_bus_hold"}, 64'(bus_ok), 64'(1));
    check_eq({tag, "_busy_ready"}, 64'(ready_ok), 64'(1));
    check_eq({tag, "_resp_valid"}, 64'(bus.resp_valid), 64'(1));
    check_eq({tag, "_resp_err"}, 64'(bus.resp_err), 64'(exp_err));
    check_eq({tag, "_resp_rdata"}, 64'(bus.resp_rdata), 64'(exp_rdata));
    check_eq({tag, "_stb_low"}, 64'(bus.stb_o), 64'(0));
    check_eq({tag, "_resp_ready"}, 64'(bus.req_ready), 64'(0));
    @(negedge clk);
    check_eq({tag, "_pulse_end"}, 64'(bus.resp_valid), 64'(0));
    check_eq({tag, "_idle_ready"}, 64'(bus.req_ready), 64'(1));
  endtask

  initial begin
    wb_req_t     r;
    wb_req_t     q[3];
    int          idx;
    int          nresp;
    int          last_acc;
    int          waits;
    bit          t_err;
    bit          t_ack;
    logic [31:0] d;

    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_sel   = '0;
    bus.dat_i     = '0;
    bus.ack_i     = 1'b0;
    bus.err_i     = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_ready", 64'(bus.req_ready), 64'(0));
    check_eq("rst_cyc", 64'({bus.cyc_o, bus.stb_o, bus.we_o}), 64'(0));
    check_eq("rst_adr_dat_sel", 64'({bus.adr_o, bus.sel_o}) | 64'(bus.dat_o), 64'(0));
    check_eq("rst_resp", 64'({bus.resp_valid, bus.resp_err, bus.resp_rdata}), 64'(0));
    reset = 1'b0;
    #1;
    check_eq("rst_release_ready", 64'(bus.req_ready), 64'(1));
    @(negedge clk);

    r = '{we: 1'b1, addr: 32'h04, wdata: 32'hAB, sel: 4'hF};
    run_txn("wr_zero_wait", r, 0, 1'b0, 1'b1, 32'hDEAD_BEEF);

    r = '{we: 1'b0, addr: 32'h08, wdata: 32'h0, sel: 4'hF};
    run_txn("rd_3_wait", r, 3, 1'b0, 1'b1, 32'hAA);

    r = '{we: 1'b0, addr: 32'h10, wdata: 32'h0, sel: 4'h3};
    run_txn("ack_err_both", r, 1, 1'b1, 1'b1, 32'h55);

    r = '{we: 1'b1, addr: 32'h14, wdata: 32'h1234, sel: 4'hC};
    run_txn("timeout", r, 100, 1'b0, 1'b0, 32'h0);

    r = '{we: 1'b0, addr: 32'h18, wdata: 32'h0, sel: 4'hF};
    run_txn("ack_on_timeout_edge", r, int'(Timeout) - 1, 1'b0, 1'b1, 32'hCAFE);

    // Stray ack while idle must not produce a response.
    bus.ack_i = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_eq("stray_ack_no_resp", 64'({bus.resp_valid, bus.cyc_o}), 64'(0));
    end
    bus.ack_i = 1'b0;
    r = '{we: 1'b0, addr: 32'h20, wdata: 32'h0, sel: 4'hF};
    run_txn("after_stray_rd", r, 2, 1'b0, 1'b1, 32'h7777_0001);

    // Reset in the second ACTIVE cycle aborts silently.
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 32'h30;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check_eq("rst_mid_cyc_up", 64'(bus.cyc_o), 64'(1));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("rst_mid_abort", 64'({bus.cyc_o, bus.resp_valid, bus.req_ready}), 64'(0));
    reset = 1'b0;
    @(negedge clk);
    r = '{we: 1'b1, addr: 32'h04, wdata: 32'h600D, sel: 4'hF};
    run_txn("post_rst_wr", r, 0, 1'b0, 1'b1, 32'h0);

    // Back-to-back with a permanently acking slave: one accept every 3 cycles, in-order responses.
    q[0] = '{we: 1'b1, addr: 32'h40, wdata: 32'h11, sel: 4'hF};
    q[1] = '{we: 1'b0, addr: 32'h44, wdata: 32'h22, sel: 4'hF};
    q[2] = '{we: 1'b1, addr: 32'h48, wdata: 32'h33, sel: 4'h1};
    d         = 32'h1234_5678;
    bus.ack_i = 1'b1;
    bus.dat_i = d;
    idx       = 0;
    nresp     = 0;
    last_acc  = -1;
    for (int c = 0; c < 20; c++) begin
      if (bus.resp_valid === 1'b1) begin
        if (nresp < 3)
          check_eq("b2b_rdata", 64'(bus.resp_rdata), 64'(q[nresp].we ? 32'h0 : d));
        check_eq("b2b_err", 64'(bus.resp_err), 64'(0));
        nresp++;
      end
      if (idx < 3) begin
        bus.req_valid = 1'b1;
        bus.req_we    = q[idx].we;
        bus.req_addr  = q[idx].addr;
        bus.req_wdata = q[idx].wdata;
        bus.req_sel   = q[idx].sel;
        if (bus.req_ready === 1'b1) begin
          if (idx > 0) check_eq("b2b_gap", 64'(c - last_acc), 64'(3));
          last_acc = c;
          idx++;
        end
      end else begin
        bus.req_valid = 1'b0;
      end
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    bus.ack_i     = 1'b0;
    check_eq("b2b_accepts", 64'(idx), 64'(3));
    check_eq("b2b_resps", 64'(nresp), 64'(3));

    for (int i = 0; i < 30; i++) begin
      r.we    = 1'($urandom_range(0, 1));
      r.addr  = $urandom & 32'hFFFF_FFFC;
      r.wdata = $urandom;
      r.sel   = 4'($urandom_range(0, 15));
      waits   = int'($urandom_range(0, 18));
      t_err   = ($urandom_range(0, 3) == 0);
      t_ack   = t_err ? 1'($urandom_range(0, 1)) : 1'b1;
      run_txn("rand", r, waits, t_err, t_ack, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wb_master_port.md
# wb_master_port

Wishbone classic-cycle master (initiator) bridging the multicycle RISC-V core's load/store unit onto the Wishbone bus, facing the existing Wishbone slave/memory wrapper. It accepts one single-beat request at a time from the core, drives `cyc`/`stb`/`we`/address/data, waits for `ack` or `err`, and returns read data or an error flag to the core. A cycle timeout guards against a slave that never responds.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; `DATA_W/8` byte selects
- `TIMEOUT`, 16, max bus-active cycles before abort; 0 disables the timeout

Ports:
- `clk`  in  1  clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `req_valid`  in  1  core request strobe
- `req_ready`  out  1  high only in IDLE; request accepted on an edge where `req_valid & req_ready`
- `req_we`  in  1  1 = write, 0 = read
- `req_addr`  in  ADDR_W  byte address
- `req_wdata`  in  DATA_W  write data
- `req_sel`  in  DATA_W/8  byte enables
- `resp_valid`  out  1  one-cycle completion pulse
- `resp_rdata`  out  DATA_W  read data; 0 for writes and errors
- `resp_err`  out  1  valid with `resp_valid`: slave `err_i` or timeout
- `cyc_o`, `stb_o`, `we_o`  out  1  Wishbone cycle, strobe, write enable
- `adr_o`  out  ADDR_W,  `dat_o`  out  DATA_W,  `sel_o`  out  DATA_W/8
- `dat_i`  in  DATA_W  slave read data
- `ack_i`, `err_i`  in  1  slave termination

## Operation
- FSM states: IDLE, ACTIVE, RESP.
- IDLE: `req_ready=1`. On accept, register `we/addr/wdata/sel` into `we_o/adr_o/dat_o/sel_o`, clear the timeout counter, go to ACTIVE.
- ACTIVE: `cyc_o=stb_o=1`. Bus outputs hold stable. Termination is sampled each edge:
  - `err_i=1`: go to RESP with `resp_err=1`, `resp_rdata=0`.
  - else `ack_i=1`: go to RESP with `resp_err=0`. For reads, `resp_rdata` captures `dat_i`; for writes, `resp_rdata=0`.
  - else, if `TIMEOUT!=0` and counter `== TIMEOUT-1`: go to RESP with `resp_err=1` (abort). Otherwise increment the counter.
- RESP: `cyc_o=stb_o=0`, `resp_valid=1` for exactly one cycle, then IDLE. No request is accepted in RESP.
- `ack_i`/`err_i` are ignored outside ACTIVE.
- Simultaneous `ack_i` and `err_i`: err wins.
- Ack on the timeout edge: ack wins.
- Timeout counter width is `$clog2(TIMEOUT+1)`. It never wraps because it is cleared on accept.
- `we_o/adr_o/dat_o/sel_o` keep their last values outside ACTIVE and are don't-care to slaves while `cyc_o=0`.

## Timing
- Reset values:
  - state IDLE
  - `req_ready=1` once reset deasserts (`req_ready=0` while `reset` is high)
  - `cyc_o=stb_o=we_o=0`
  - `adr_o=dat_o=0`, `sel_o=0`
  - `resp_valid=resp_err=0`, `resp_rdata=0`
- Request accepted at edge N → `cyc_o/stb_o` high in cycle N+1.
- Ack sampled at edge N+k (k≥1) → `cyc_o` low and `resp_valid` high in cycle N+k+1 → IDLE at N+k+2.
- Minimum request-to-response is 2 cycles; back-to-back throughput is one transfer per 3 cycles with a zero-wait slave.
- Timeout: with no termination, `resp_err` pulses in cycle N+TIMEOUT+1.
- Reset asserted mid-ACTIVE: the next edge forces IDLE, drops `cyc_o/stb_o`, and emits no `resp_valid`. The core must reissue.

## Structure
- Shared package `wb_pkg`:
  - `wb_state_t` enum {IDLE, ACTIVE, RESP}
  - default `ADDR_W`/`DATA_W` constants
  - packed request struct (`we`, `addr`, `wdata`, `sel`), shared with the slave-side testbench
- One natural sub-module, `wb_timeout_ctr`: clear, enable, parameter `TIMEOUT`, `expired` output; tied off when `TIMEOUT=0`.
- Everything else is a single `always_ff` FSM plus output registers.

## Test plan
- Write, zero-wait: `req_we=1`, `addr=32'h04`, `wdata=32'hAB`, `sel=4'hF`; slave acks in the first ACTIVE cycle → `cyc_o` high exactly 1 cycle with `adr_o=32'h04`, `dat_o=32'hAB`, `we_o=1`; `resp_valid` 1 cycle later with `resp_err=0`, `resp_rdata=0`.
- Read, 3 wait states: read `32'h08`; slave returns `dat_i=32'hAA` with `ack_i` on the 4th ACTIVE cycle → `cyc_o` high 4 cycles, `resp_rdata=32'hAA`, `resp_err=0`; `req_ready` low throughout.
- Error/timeout: slave raises `err_i` and `ack_i` together → `resp_err=1`, `resp_rdata=0`. Separately, `TIMEOUT=16` with no ack → `resp_err=1` exactly 17 cycles after accept, `cyc_o` dropped.
- Stray ack: `ack_i` pulsed while IDLE, then a read issued → no `resp_valid` from the stray pulse; the read completes normally.
- Reset mid-cycle: assert `reset` on the 2nd ACTIVE cycle → next cycle `cyc_o=0`, `resp_valid=0`, `req_ready=0`; after release, a new write to `32'h04` completes normally.
- Back-to-back: hold `req_valid=1` with 3 queued requests against a zero-wait slave → accepts every 3 cycles, 3 `resp_valid` pulses in order.
